// File: rtl/result_streamer.sv
// Streams a block of bytes out of result memory to an Avalon-ST byte sink.
// Optional READBACK_CHECKSUM_EN appends one XOR checksum byte after the payload.
module result_streamer #(
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        sink_data,
  output logic              sink_valid,
  input  logic              sink_ready,
  output logic              busy,
  output logic              done
);

  // The WAIT state assumes the memory returns data exactly one cycle after the strobe.
  generate
    if (RD_LATENCY != 1) begin : g_bad_latency
      $error("result_streamer: only RD_LATENCY == 1 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    SEND   = 3'd3,
`ifdef READBACK_CHECKSUM_EN
    CSUM   = 3'd4,
`endif
    FINISH = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [7:0]        data_reg, data_next;
  logic [ADDR_W:0]   count_inc;
`ifdef READBACK_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  assign count_inc = {1'b0, count_reg} + 1'b1;
  assign mem_addr  = base_reg + count_reg;
  assign sink_data = data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      len_reg   <= '0;
      count_reg <= '0;
      data_reg  <= '0;
`ifdef READBACK_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      len_reg   <= len_next;
      count_reg <= count_next;
      data_reg  <= data_next;
`ifdef READBACK_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    len_next   = len_reg;
    count_next = count_reg;
    data_next  = data_reg;
`ifdef READBACK_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    mem_rd_en  = 1'b0;
    sink_valid = 1'b0;
    done       = 1'b0;
    busy       = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (start) begin
          base_next  = base_addr;
          len_next   = length;
          count_next = '0;
`ifdef READBACK_CHECKSUM_EN
          csum_next  = '0;
`endif
          state_next = (length == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        mem_rd_en  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        data_next  = mem_rdata;
        state_next = SEND;
      end
      SEND: begin
        sink_valid = 1'b1;
        if (sink_ready) begin
          count_next = count_inc[ADDR_W-1:0];
`ifdef READBACK_CHECKSUM_EN
          csum_next  = csum_reg ^ data_reg;
`endif
          if (count_inc < {1'b0, len_reg}) begin
            state_next = FETCH;
          end else begin
`ifdef READBACK_CHECKSUM_EN
            // The checksum byte reuses the output register so the sink sees one data path.
            data_next  = csum_reg ^ data_reg;
            state_next = CSUM;
`else
            state_next = FINISH;
`endif
          end
        end
      end
`ifdef READBACK_CHECKSUM_EN
      CSUM: begin
        sink_valid = 1'b1;
        if (sink_ready) begin
          state_next = FINISH;
        end
      end
`endif
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: memory model, byte/address monitor, assertion checks.
module tb_result_streamer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  logic [7:0]  mem [0:65535];
  logic [7:0]  got_q[$];
  logic [15:0] addr_q[$];
  int          done_cnt;

  result_streamer #(.ADDR_W(16), .RD_LATENCY(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .sink_data (sink_data),
    .sink_valid(sink_valid),
    .sink_ready(sink_ready),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered-read result memory, one cycle latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Monitor samples on the falling edge; inputs only change at posedge+1
  always @(negedge clk) begin
    if (sink_valid && sink_ready) begin
      got_q.push_back(sink_data);
      $display("xfer byte 0x%02h", sink_data);
    end
    if (mem_rd_en) addr_q.push_back(mem_addr);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp[i]);
  endtask

  task automatic start_stream(input logic [15:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    got_q.delete();
    addr_q.delete();
    done_cnt  = 0;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 16'h0000;
    length    = 16'h0000;
  endtask

  task automatic wait_done(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, found, 1'b1);
    @(posedge clk); #1;
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_done_once"}, done_cnt, 1);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    checks     = 0;
    errors     = 0;
    done_cnt   = 0;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    length     = '0;
    sink_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h11;
    mem[16'h0011] = 8'h22;
    mem[16'h0012] = 8'h33;
    mem[16'h0013] = 8'h44;
    mem[16'h0100] = 8'hEE;
    mem[16'hFFFF] = 8'hA5;
    mem[16'h0000] = 8'h5A;
    for (int i = 0; i < 8; i++) mem[16'h0020 + i] = 8'h31 + 8'(i);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sink_valid", sink_valid, 1'b0);
    check("rst_mem_rd_en", mem_rd_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sink_data", sink_data, 8'h00);
    check("rst_mem_addr", mem_addr, 16'h0000);

    // Basic stream; start accepted on first edge after reset release
    @(posedge clk); #1;
    reset     = 1'b0;
    got_q.delete();
    addr_q.delete();
    done_cnt  = 0;
    start     = 1'b1;
    base_addr = 16'h0010;
    length    = 16'd4;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 16'h0000;
    length    = 16'h0000;
    check("t1_fetch_rd_en", mem_rd_en, 1'b1);
    check("t1_fetch_addr", mem_addr, 16'h0010);
    check("t1_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("t1_wait_valid", sink_valid, 1'b0);
    check("t1_wait_rd_en", mem_rd_en, 1'b0);
    @(posedge clk); #1;
    check("t1_first_valid", sink_valid, 1'b1);
    check("t1_first_data", sink_data, 8'h11);
    wait_done("t1");
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef READBACK_CHECKSUM_EN
    exp_q.push_back(8'h44);
`endif
    check_bytes("t1", exp_q);

    // Backpressure: hold sink_ready low for 5 cycles while byte 0x22 is offered
    start_stream(16'h0010, 16'd4);
    for (int i = 0; i < 50; i++) begin
      if (sink_valid && sink_data == 8'h22) break;
      @(posedge clk); #1;
    end
    sink_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t2_stall_valid%0d", k), sink_valid, 1'b1);
      check($sformatf("t2_stall_data%0d", k), sink_data, 8'h22);
      @(posedge clk); #1;
    end
    sink_ready = 1'b1;
    wait_done("t2");
    check_bytes("t2", exp_q);

    // Address wrap at top of memory
    start_stream(16'hFFFF, 16'd2);
    wait_done("t3");
    check("t3_addr_count", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      check("t3_addr0", addr_q[0], 16'hFFFF);
      check("t3_addr1", addr_q[1], 16'h0000);
    end
    exp_q = '{8'hA5, 8'h5A};
`ifdef READBACK_CHECKSUM_EN
    exp_q.push_back(8'hFF);
`endif
    check_bytes("t3", exp_q);

    // Zero length
    start_stream(16'h0040, 16'd0);
    check("t4_done", done, 1'b1);
    check("t4_busy", busy, 1'b1);
    check("t4_valid", sink_valid, 1'b0);
    check("t4_rd_en", mem_rd_en, 1'b0);
    @(posedge clk); #1;
    check("t4_done_after", done, 1'b0);
    check("t4_busy_after", busy, 1'b0);
    check("t4_no_bytes", got_q.size(), 0);
    check("t4_done_once", done_cnt, 1);

    // Start while busy is ignored
    start_stream(16'h0010, 16'd4);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 16'h0100;
    length    = 16'd3;
    @(posedge clk); #1;
    start     = 1'b0;
    wait_done("t5");
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef READBACK_CHECKSUM_EN
    exp_q.push_back(8'h44);
`endif
    check_bytes("t5", exp_q);
    check("t5_addr_count", addr_q.size(), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      check($sformatf("t5_addr%0d", i), addr_q[i], 16'h0010 + 16'(i));

    // Reset while byte 3 of 8 is on the sink
    start_stream(16'h0020, 16'd8);
    for (int i = 0; i < 50; i++) begin
      if (sink_valid && sink_data == 8'h33) break;
      @(posedge clk); #1;
    end
    check("t6_reached_byte3", sink_data, 8'h33);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", sink_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_rd_en", mem_rd_en, 1'b0);
    check("t6_rst_data", sink_data, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt, 0);
    check("t6_partial_bytes", got_q.size(), 2);
    start_stream(16'h0020, 16'd8);
    wait_done("t6");
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
`ifdef READBACK_CHECKSUM_EN
    exp_q.push_back(8'h08);
`endif
    check_bytes("t6", exp_q);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
